// File: rtl/rob_commit.sv
// ============================================================================
// Module   : rob_commit
// Purpose  : Circular reorder buffer with in-order commit, store release and
//            branch-mispredict flush/redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_commit #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_valid,
  input  logic [1:0]       issue_type,
  input  logic [4:0]       issue_rd,
  input  logic             issue_pred_taken,
  output logic             rob_full,
  output logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_next_pc,
  output logic             commit_reg_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_data,
  output logic [TAG_W-1:0] commit_tag,
  output logic             commit_store,
  output logic             clear,
  output logic [31:0]      redirect_pc
);

  localparam logic [TAG_W:0] c_depth       = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [1:0]     c_type_reg    = 2'd0;
  localparam logic [1:0]     c_type_store  = 2'd1;
  localparam logic [1:0]     c_type_branch = 2'd2;

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [1:0]           type_q  [ROB_DEPTH];
  logic [4:0]           rd_q    [ROB_DEPTH];
  logic [31:0]          value_q [ROB_DEPTH];
  logic                 pred_q  [ROB_DEPTH];
  logic                 taken_q [ROB_DEPTH];
  logic [31:0]          npc_q   [ROB_DEPTH];

  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic do_issue;
  logic do_commit;
  logic cdb_hit;
  logic mispredict;

  assign rob_full  = (count_q == c_depth);
  assign issue_tag = tail_q;
  assign do_issue  = issue_valid && !rob_full;
  // Commit looks only at registered ready, so a CDB write to head waits a cycle.
  assign do_commit = (count_q != '0) && ready_q[head_q];
  assign cdb_hit   = cdb_valid && busy_q[cdb_tag];
  assign mispredict = do_commit && (type_q[head_q] == c_type_branch) &&
                      (taken_q[head_q] != pred_q[head_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q           <= '0;
      ready_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      commit_reg_valid <= 1'b0;
      commit_store     <= 1'b0;
      clear            <= 1'b0;
      commit_rd        <= '0;
      commit_data      <= '0;
      commit_tag       <= '0;
      redirect_pc      <= '0;
    end else if (!rdy) begin
      commit_reg_valid <= 1'b0;
      commit_store     <= 1'b0;
      clear            <= 1'b0;
    end else begin
      commit_reg_valid <= 1'b0;
      commit_store     <= 1'b0;
      clear            <= 1'b0;
      if (mispredict) begin
        // Flush drops every entry plus this cycle's issue and CDB write.
        busy_q      <= '0;
        ready_q     <= '0;
        head_q      <= '0;
        tail_q      <= '0;
        count_q     <= '0;
        clear       <= 1'b1;
        redirect_pc <= npc_q[head_q];
        commit_tag  <= head_q;
      end else begin
        if (cdb_hit) begin
          ready_q[cdb_tag] <= 1'b1;
          value_q[cdb_tag] <= cdb_value;
          taken_q[cdb_tag] <= cdb_taken;
          npc_q[cdb_tag]   <= cdb_next_pc;
        end
        if (do_issue) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          type_q[tail_q]  <= issue_type;
          rd_q[tail_q]    <= issue_rd;
          pred_q[tail_q]  <= issue_pred_taken;
          tail_q          <= tail_q + 1'b1;
        end
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
          commit_tag      <= head_q;
          if (type_q[head_q] == c_type_reg) begin
            commit_reg_valid <= 1'b1;
            commit_rd        <= rd_q[head_q];
            commit_data      <= value_q[head_q];
          end
          if (type_q[head_q] == c_type_store) begin
            commit_store <= 1'b1;
          end
        end
        if (do_issue && !do_commit) begin
          count_q <= count_q + 1'b1;
        end else if (!do_issue && do_commit) begin
          count_q <= count_q - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit.
`default_nettype none

module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic        rob_full;
  logic [2:0]  issue_tag;
  logic        cdb_valid, cdb_taken;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_next_pc;
  logic        commit_reg_valid, commit_store, clear;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, redirect_pc;
  logic [2:0]  commit_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rob_commit #(.ROB_DEPTH(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .rob_full(rob_full), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .cdb_next_pc(cdb_next_pc),
    .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .commit_store(commit_store), .clear(clear), .redirect_pc(redirect_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pred_taken = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0; cdb_next_pc = 0;
  endtask

  task automatic do_reset();
    idle(); rdy = 1; rst = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pt);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_pred_taken = pt;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] val,
                     input logic tk, input logic [31:0] npc);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val; cdb_taken = tk; cdb_next_pc = npc;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rob_full, issue_tag, commit_reg_valid, commit_store, clear} !== 7'd0 ||
        commit_rd !== 5'd0 || commit_data !== 32'd0 || commit_tag !== 3'd0 ||
        redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: full=%0b tag=%0d crv=%0b cs=%0b clr=%0b rd=%0d data=%h ctag=%0d rpc=%h, required all 0",
               rob_full, issue_tag, commit_reg_valid, commit_store, clear, commit_rd,
               commit_data, commit_tag, redirect_pc);
    end
  endtask

  task automatic test_reg_commit();
    do_reset();
    issue(2'd0, 5'd5, 1'b0); step(); idle();
    n_checks++;
    if (issue_tag !== 3'd1) begin
      n_fail++; $display("FAIL reg_issue_tag: got %0d required 1", issue_tag);
    end
    cdb(3'd0, 32'h1234, 1'b0, 32'h0); step(); idle();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL reg_no_early_commit: got %0b required 0", commit_reg_valid);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_rd !== 5'd5 || commit_data !== 32'h1234 ||
        commit_tag !== 3'd0) begin
      n_fail++;
      $display("FAIL reg_commit: valid=%0b rd=%0d data=%h tag=%0d required 1/5/00001234/0",
               commit_reg_valid, commit_rd, commit_data, commit_tag);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL reg_pulse_width: got %0b required 0", commit_reg_valid);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      issue(2'd0, 5'(i), 1'b0); step();
    end
    n_checks++;
    if (rob_full !== 1'b1 || issue_tag !== 3'd0) begin
      n_fail++; $display("FAIL full_after_8: full=%0b tag=%0d required 1/0", rob_full, issue_tag);
    end
    issue(2'd0, 5'd31, 1'b0); step();
    n_checks++;
    if (rob_full !== 1'b1 || issue_tag !== 3'd0) begin
      n_fail++; $display("FAIL ninth_ignored: full=%0b tag=%0d required 1/0", rob_full, issue_tag);
    end
    idle(); cdb(3'd0, 32'hAA, 1'b0, 32'h0); step(); idle();
    // Issue held high on the commit edge must not be accepted while full.
    issue(2'd0, 5'd20, 1'b0); step();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_rd !== 5'd0 || commit_data !== 32'hAA ||
        rob_full !== 1'b0 || issue_tag !== 3'd0) begin
      n_fail++;
      $display("FAIL full_commit: valid=%0b rd=%0d data=%h full=%0b tag=%0d required 1/0/000000aa/0/0",
               commit_reg_valid, commit_rd, commit_data, rob_full, issue_tag);
    end
    step(); idle();
    n_checks++;
    if (issue_tag !== 3'd1 || rob_full !== 1'b1) begin
      n_fail++; $display("FAIL wrap_issue: tag=%0d full=%0b required 1/1", issue_tag, rob_full);
    end
    cdb(3'd1, 32'hBB, 1'b0, 32'h0); step(); idle(); step();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_rd !== 5'd1 || commit_tag !== 3'd1) begin
      n_fail++; $display("FAIL wrap_second_commit: valid=%0b rd=%0d tag=%0d required 1/1/1",
                         commit_reg_valid, commit_rd, commit_tag);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    issue(2'd0, 5'd3, 1'b0); step();
    issue(2'd0, 5'd4, 1'b0); step(); idle();
    cdb(3'd1, 32'h11, 1'b0, 32'h0); step();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_no_commit_young: got %0b required 0", commit_reg_valid);
    end
    cdb(3'd0, 32'h22, 1'b0, 32'h0); step(); idle();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_no_commit_same_cycle: got %0b required 0", commit_reg_valid);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_tag !== 3'd0 || commit_rd !== 5'd3 ||
        commit_data !== 32'h22) begin
      n_fail++; $display("FAIL ooo_first: valid=%0b tag=%0d rd=%0d data=%h required 1/0/3/00000022",
                         commit_reg_valid, commit_tag, commit_rd, commit_data);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_tag !== 3'd1 || commit_rd !== 5'd4 ||
        commit_data !== 32'h11) begin
      n_fail++; $display("FAIL ooo_second: valid=%0b tag=%0d rd=%0d data=%h required 1/1/4/00000011",
                         commit_reg_valid, commit_tag, commit_rd, commit_data);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_drain: got %0b required 0", commit_reg_valid);
    end
  endtask

  task automatic test_branch_ok();
    do_reset();
    issue(2'd2, 5'd0, 1'b1); step(); idle();
    cdb(3'd0, 32'h0, 1'b1, 32'h200); step(); idle(); step();
    n_checks++;
    if (clear !== 1'b0 || commit_reg_valid !== 1'b0 || commit_store !== 1'b0 || issue_tag !== 3'd1) begin
      n_fail++; $display("FAIL branch_ok_silent: clr=%0b crv=%0b cs=%0b tag=%0d required 0/0/0/1",
                         clear, commit_reg_valid, commit_store, issue_tag);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(2'd2, 5'd0, 1'b0); step();
    for (int i = 1; i < 4; i++) begin
      issue(2'd0, 5'(i), 1'b0); step();
    end
    cdb(3'd0, 32'h0, 1'b1, 32'h100); step();
    n_checks++;
    if (clear !== 1'b0 || issue_tag !== 3'd5) begin
      n_fail++; $display("FAIL mp_before_flush: clr=%0b tag=%0d required 0/5", clear, issue_tag);
    end
    cdb(3'd1, 32'h77, 1'b0, 32'h0); step(); idle();
    n_checks++;
    if (clear !== 1'b1 || redirect_pc !== 32'h100 || issue_tag !== 3'd0 || rob_full !== 1'b0 ||
        commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL mp_flush: clr=%0b rpc=%h tag=%0d full=%0b crv=%0b required 1/00000100/0/0/0",
                         clear, redirect_pc, issue_tag, rob_full, commit_reg_valid);
    end
    step();
    n_checks++;
    if (clear !== 1'b0) begin
      n_fail++; $display("FAIL mp_clear_width: got %0b required 0", clear);
    end
    for (int i = 0; i < 7; i++) begin
      issue(2'd0, 5'd9, 1'b0); step();
    end
    n_checks++;
    if (rob_full !== 1'b0) begin
      n_fail++; $display("FAIL mp_count_zero_7: full=%0b required 0", rob_full);
    end
    step(); idle();
    n_checks++;
    if (rob_full !== 1'b1) begin
      n_fail++; $display("FAIL mp_count_zero_8: full=%0b required 1", rob_full);
    end
  endtask

  task automatic test_store_rdy();
    do_reset();
    issue(2'd1, 5'd0, 1'b0); step();
    rdy = 0;
    cdb(3'd0, 32'h99, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (issue_tag !== 3'd1 || commit_store !== 1'b0) begin
        n_fail++; $display("FAIL store_frozen: tag=%0d cs=%0b required 1/0", issue_tag, commit_store);
      end
    end
    rdy = 1; idle(); cdb(3'd0, 32'h99, 1'b0, 32'h0); step(); idle();
    n_checks++;
    if (commit_store !== 1'b0) begin
      n_fail++; $display("FAIL store_early: got %0b required 0", commit_store);
    end
    step();
    n_checks++;
    if (commit_store !== 1'b1 || commit_tag !== 3'd0 || commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL store_commit: cs=%0b tag=%0d crv=%0b required 1/0/0",
                         commit_store, commit_tag, commit_reg_valid);
    end
    step();
    n_checks++;
    if (commit_store !== 1'b0) begin
      n_fail++; $display("FAIL store_once: got %0b required 0", commit_store);
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    issue(2'd0, 5'd7, 1'b0); step();
    issue(2'd0, 5'd9, 1'b0); step(); idle();
    cdb(3'd0, 32'h55, 1'b0, 32'h0); step();
    cdb(3'd1, 32'h66, 1'b0, 32'h0); step(); idle();
    n_checks++;
    if (commit_reg_valid !== 1'b1 || commit_data !== 32'h55) begin
      n_fail++; $display("FAIL rstp_setup: crv=%0b data=%h required 1/00000055", commit_reg_valid, commit_data);
    end
    rst = 1; rdy = 0; step(); rst = 0; rdy = 1;
    n_checks++;
    if (commit_reg_valid !== 1'b0 || commit_store !== 1'b0 || clear !== 1'b0 ||
        commit_rd !== 5'd0 || commit_data !== 32'd0 || commit_tag !== 3'd0 ||
        redirect_pc !== 32'd0 || issue_tag !== 3'd0) begin
      n_fail++; $display("FAIL rstp_cleared: crv=%0b cs=%0b clr=%0b rd=%0d data=%h ctag=%0d rpc=%h itag=%0d required all 0",
                         commit_reg_valid, commit_store, clear, commit_rd, commit_data,
                         commit_tag, redirect_pc, issue_tag);
    end
    step();
    n_checks++;
    if (commit_reg_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstp_no_pulse: got %0b required 0", commit_reg_valid);
    end
  endtask

  initial begin
    idle(); rst = 1; rdy = 1;
    test_reset();
    test_reg_commit();
    test_full_wrap();
    test_out_of_order();
    test_branch_ok();
    test_mispredict();
    test_store_rdy();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 The block SHALL have parameter ROB_DEPTH, default 8, giving the number of reorder entries (power of two).
REQ-002 The block SHALL have parameter TAG_W, default 3, equal to log2(ROB_DEPTH).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rdy  input  1  global enable; low freezes all state.
REQ-006 issue_valid  input  1  allocate one entry this cycle.
REQ-007 issue_type  input  2  entry type: 0 REG-write, 1 STORE, 2 BRANCH.
REQ-008 issue_rd  input  5  destination register; don't-care unless REG.
REQ-009 issue_pred_taken  input  1  predictor direction; don't-care unless BRANCH.
REQ-010 rob_full  output  1  combinational; count equals ROB_DEPTH.
REQ-011 issue_tag  output  TAG_W  combinational; current tail index, the tag given to the instruction being issued.
REQ-012 cdb_valid  input  1  one execution result this cycle.
REQ-013 cdb_tag  input  TAG_W  entry the result belongs to.
REQ-014 cdb_value  input  32  result value, or store data.
REQ-015 cdb_taken  input  1  resolved branch direction.
REQ-016 cdb_next_pc  input  32  correct next PC of the resolved branch.
REQ-017 commit_reg_valid  output  1  registered one-cycle pulse; write back to the register file.
REQ-018 commit_rd  output  5  register written at commit.
REQ-019 commit_data  output  32  value written at commit.
REQ-020 commit_tag  output  TAG_W  tag of the committing entry; the register file compares it with its rename tag to decide whether to clear busy.
REQ-021 commit_store  output  1  registered one-cycle pulse; the store at commit_tag may write memory.
REQ-022 clear  output  1  registered one-cycle pulse; mispredict flush to every pipeline unit.
REQ-023 redirect_pc  output  32  fetch target; valid while clear is high.

Function
REQ-024 The block SHALL be a circular buffer with head, tail and count (0..ROB_DEPTH); pointers wrap modulo ROB_DEPTH.
REQ-025 Each entry SHALL store: busy, ready, type, rd, value, pred_taken, taken, next_pc.
REQ-026 Issue SHALL occur when issue_valid and !rob_full: entry[tail] is written with busy=1, ready=0 and the issue fields; tail advances by 1.
REQ-027 When rob_full is high, issue_valid SHALL be ignored and no state SHALL change for it.
REQ-028 On cdb_valid with entry[cdb_tag].busy=1, the block SHALL set ready=1 and write value, taken and next_pc.
REQ-029 On cdb_valid with entry[cdb_tag].busy=0, the result SHALL be ignored.
REQ-030 At most one commit SHALL occur per cycle, and only when count>0 and entry[head].ready=1, using ready as registered at the start of that cycle; a CDB write to head SHALL therefore commit no earlier than the following cycle.
REQ-031 A commit SHALL clear entry[head].busy and advance head by 1.
REQ-032 All commit outputs SHALL update on the commit edge and be visible for exactly one cycle.
REQ-033 A REG commit SHALL pulse commit_reg_valid, with commit_rd, commit_data and commit_tag from the entry; rd=0 still pulses.
REQ-034 A STORE commit SHALL pulse commit_store with commit_tag.
REQ-035 A BRANCH commit with taken==pred_taken SHALL retire silently, with no output pulse.
REQ-036 A BRANCH commit with taken!=pred_taken SHALL pulse clear and drive redirect_pc=next_pc.
REQ-037 On that same edge, head=tail=count=0, all entries SHALL become non-busy, and any issue or CDB write in that cycle SHALL be discarded.
REQ-038 When issue and commit occur in the same cycle, count SHALL be unchanged; a full ROB SHALL accept a new issue only on the cycle after a commit.
REQ-039 When rdy=0, all state SHALL hold and pulse outputs SHALL be driven to 0 on that edge.
REQ-040 On any edge without a commit or flush, commit_reg_valid, commit_store and clear SHALL return to 0.

Reset
REQ-041 On rst, head, tail and count SHALL be 0 and every entry non-busy and non-ready.
REQ-042 On rst, commit_reg_valid, commit_store and clear SHALL be 0, and commit_rd, commit_data, commit_tag and redirect_pc SHALL be 0.
REQ-043 rst SHALL take priority over rdy and over any in-flight commit or flush.

Verification
REQ-044 Scenario: issue REG rd=5 (tag 0), then CDB tag 0 value 0x1234 -> one cycle later commit_reg_valid=1, commit_rd=5, commit_data=0x1234, commit_tag=0.
REQ-045 Scenario: issue 8 entries -> rob_full=1 and a 9th issue is ignored; after one commit, the next issue gets tag 0 (wrap-around).
REQ-046 Scenario: issue tags 0,1; CDB tag 1 first, then tag 0 -> commits occur in order 0 then 1, on consecutive cycles.
REQ-047 Scenario: BRANCH pred_taken=0, CDB taken=1, next_pc=0x100, followed by 3 younger issues -> clear=1 and redirect_pc=0x100 for one cycle; count=0 after, and the next issue_tag is 0.
REQ-048 Scenario: STORE commit with rdy dropped for 2 cycles before the CDB write -> no state change while rdy=0; commit_store pulses exactly once after rdy returns.
REQ-049 Scenario: rst asserted during a pending commit -> no pulse, and all outputs are 0 on the next cycle.
